// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the MAXNET winner-take-all controller.
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    DONE
  } state_t;

  localparam int unsigned NCAND             = 4;
  localparam int unsigned W_DEFAULT         = 8;
  localparam int unsigned EPS_SHIFT_DEFAULT = 3;
  localparam int unsigned MAX_ITER_DEFAULT  = 32;

  function automatic logic [2:0] count_nz(input logic [NCAND-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NCAND; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/maxnet_pe.sv
// One candidate's lateral-inhibition update: x - ((S - x) >> EPS_SHIFT), clamped at 0.
module maxnet_pe
  import maxnet_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int unsigned EPS_SHIFT = EPS_SHIFT_DEFAULT
) (
  input  logic [W-1:0] x_i,
  input  logic [W+1:0] sum_i,
  output logic [W-1:0] x_o
);

  logic signed [W+2:0] rest;
  logic signed [W+2:0] inh;
  logic signed [W+2:0] res;

  always_comb begin
    rest = $signed({1'b0, sum_i}) - $signed({3'b000, x_i});
    inh  = rest >>> EPS_SHIFT;
    res  = $signed({3'b000, x_i}) - inh;
    x_o  = (res < 0) ? '0 : res[W-1:0];
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// Four-candidate MAXNET winner-take-all search controller.
// Define MAXNET_ITER_COUNT_EN to expose the executed iteration count on iter_cnt.
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int unsigned EPS_SHIFT = EPS_SHIFT_DEFAULT,
  parameter int unsigned MAX_ITER  = MAX_ITER_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 start,
  input  logic [NCAND*W-1:0]   in_vec,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
`ifdef MAXNET_ITER_COUNT_EN
  output logic                 tie,
  output logic [7:0]           iter_cnt
`else
  output logic                 tie
`endif
);

  state_t                    state_q, state_d;
  logic [NCAND-1:0][W-1:0]   x_q, x_d, x_nxt;
  logic [7:0]                cnt_q, cnt_d;
  logic [1:0]                winner_q, winner_d;
  logic                      tie_q, tie_d;
  logic [W+1:0]              sum;
  logic [NCAND-1:0]          nz_vec;
  logic [2:0]                nz;

  always_comb begin
    sum    = '0;
    nz_vec = '0;
    for (int unsigned i = 0; i < NCAND; i++) begin
      sum       = sum + (W+2)'(x_q[i]);
      nz_vec[i] = |x_q[i];
    end
    nz = count_nz(nz_vec);
  end

  for (genvar g = 0; g < NCAND; g++) begin : g_pe
    maxnet_pe #(
      .W        (W),
      .EPS_SHIFT(EPS_SHIFT)
    ) u_pe (
      .x_i  (x_q[g]),
      .sum_i(sum),
      .x_o  (x_nxt[g])
    );
  end

  // winner/tie change only when a result is produced, so they hold past DONE.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = in_vec;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (nz == 3'd1) begin
          tie_d    = 1'b0;
          winner_d = '0;
          for (int unsigned i = 0; i < NCAND; i++) begin
            if (nz_vec[i]) winner_d = 2'(i);
          end
          state_d = DONE;
        end else if (nz == 3'd0 || cnt_q == 8'(MAX_ITER)) begin
          tie_d    = 1'b1;
          winner_d = '0;
          state_d  = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        x_d     = x_nxt;
        cnt_d   = cnt_q + 8'd1;
        state_d = CHECK;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= IDLE;
      x_q      <= '0;
      cnt_q    <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign winner = winner_q;
  assign tie    = tie_q;
`ifdef MAXNET_ITER_COUNT_EN
  assign iter_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Self-checking bench for maxnet_ctrl against an arithmetic winner-take-all reference.
module tb_maxnet_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned EPS  = 3;
  localparam int unsigned MAXI = 32;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             start;
  logic [4*W-1:0]   in_vec;
  logic             busy, done, tie;
  logic [1:0]       winner;
`ifdef MAXNET_ITER_COUNT_EN
  logic [7:0]       iter_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  maxnet_ctrl #(
    .W        (W),
    .EPS_SHIFT(EPS),
    .MAX_ITER (MAXI)
  ) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .start (start),
    .in_vec(in_vec),
    .busy  (busy),
    .done  (done),
    .winner(winner),
`ifdef MAXNET_ITER_COUNT_EN
    .tie   (tie),
    .iter_cnt(iter_cnt)
`else
    .tie   (tie)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: iterate the inhibition rule on plain integers until one survivor,
  // none, or the iteration limit.
  function automatic void model(input logic [31:0] v, output int w, output bit t, output int n);
    int x[4];
    int nx[4];
    int s, nzc, idx;
    for (int i = 0; i < 4; i++) x[i] = int'(v[i*8 +: 8]);
    n = 0;
    w = 0;
    t = 1'b1;
    while (1) begin
      nzc = 0;
      idx = 0;
      for (int i = 0; i < 4; i++) if (x[i] != 0) begin nzc++; idx = i; end
      if (nzc == 1) begin w = idx; t = 1'b0; return; end
      if (nzc == 0 || n == int'(MAXI)) begin w = 0; t = 1'b1; return; end
      s = x[0] + x[1] + x[2] + x[3];
      for (int i = 0; i < 4; i++) begin
        nx[i] = x[i] - (s - x[i]) / (1 << EPS);
        if (nx[i] < 0) nx[i] = 0;
      end
      x = nx;
      n++;
    end
  endfunction

  task automatic run(input logic [31:0] v, input bit disturb, input string tag);
    int  ew, en, k;
    bit  et, seen;
    logic [1:0] w_hold;
    logic       t_hold;
    model(v, ew, et, en);
    @(negedge CLK);
    in_vec = v;
    start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check({tag, ".busy_acc"}, 32'(busy), 32'd1);
    seen = 1'b0;
    k    = 1;
    while (!seen && k < int'(2*MAXI + 12)) begin
      @(posedge CLK); #1;
      k++;
      if (done) seen = 1'b1;
      else if (disturb) begin
        start  = 1'($urandom_range(0, 1));
        in_vec = $urandom;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(2*en + 2));
    if (seen) begin
      check({tag, ".winner"}, 32'(winner), 32'(ew));
      check({tag, ".tie"}, 32'(tie), 32'(et));
      check({tag, ".busy_done"}, 32'(busy), 32'd1);
`ifdef MAXNET_ITER_COUNT_EN
      check({tag, ".iter_cnt"}, 32'(iter_cnt), 32'(en));
`endif
    end
    w_hold = 2'(ew);
    t_hold = et;
    @(posedge CLK); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".winner_hold"}, 32'(winner), 32'(w_hold));
    check({tag, ".tie_hold"}, 32'(tie), 32'(t_hold));
`ifdef MAXNET_ITER_COUNT_EN
    check({tag, ".iter_hold"}, 32'(iter_cnt), 32'(en));
`endif
  endtask

  function automatic logic [31:0] rand_vec();
    logic [7:0] b[4];
    int mode;
    mode = int'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    case (mode)
      1: for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 0) b[i] = '0;
      2: b[$urandom_range(0, 3)] = b[$urandom_range(0, 3)];
      3: for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 20));
      default: ;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  localparam logic [31:0] V025 = {8'd200, 8'd30, 8'd20, 8'd10};
  localparam logic [31:0] V026 = {8'd0, 8'd55, 8'd0, 8'd0};
  localparam logic [31:0] V028 = {8'd0, 8'd0, 8'd50, 8'd50};

  initial begin
    CLR    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    #12;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.winner", 32'(winner), 32'd0);
    check("reset.tie", 32'(tie), 32'd0);
    @(negedge CLK);
    CLR = 1'b0;

    run(V025, 1'b0, "r025");
    run(V026, 1'b0, "r026");
    run(32'd0, 1'b0, "r027");
    run(V028, 1'b0, "r028");
    run(V026, 1'b0, "r026b");

    // Asynchronous clear while the first ITER is in progress.
    @(negedge CLK);
    in_vec = V025;
    start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #2;
    CLR = 1'b1;
    #1;
    check("clr.busy", 32'(busy), 32'd0);
    check("clr.done", 32'(done), 32'd0);
    check("clr.winner", 32'(winner), 32'd0);
    check("clr.tie", 32'(tie), 32'd0);
`ifdef MAXNET_ITER_COUNT_EN
    check("clr.iter_cnt", 32'(iter_cnt), 32'd0);
`endif
    @(posedge CLK); #1;
    check("clr.held_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("clr.no_done", 32'(done), 32'd0);
      check("clr.idle", 32'(busy), 32'd0);
    end
    run(V025, 1'b0, "r029");

    // start held high across two runs: second run accepted on the edge after DONE.
    @(negedge CLK);
    in_vec = V026;
    start  = 1'b1;
    @(posedge CLK); #1;
    check("hold.acc1", 32'(busy), 32'd1);
    @(posedge CLK); #1;
    check("hold.done1", 32'(done), 32'd1);
    check("hold.win1", 32'(winner), 32'd2);
    @(posedge CLK); #1;
    check("hold.idle", 32'(busy), 32'd0);
    check("hold.nodone", 32'(done), 32'd0);
    @(posedge CLK); #1;
    check("hold.acc2", 32'(busy), 32'd1);
    check("hold.acc2_done", 32'(done), 32'd0);
    @(posedge CLK); #1;
    check("hold.done2", 32'(done), 32'd1);
    check("hold.win2", 32'(winner), 32'd2);
    start = 1'b0;
    @(posedge CLK); #1;
    check("hold.end", 32'(busy), 32'd0);

    run(V025, 1'b1, "r030d");

    for (int r = 0; r < 24; r++) begin
      run(rand_vec(), 1'(r % 2), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 The block SHALL have parameter W, 8, unsigned width of each candidate activation.
REQ-002 The block SHALL have parameter EPS_SHIFT, 3, inhibition weight epsilon = 2^-EPS_SHIFT, applied as a right shift.
REQ-003 The block SHALL have parameter MAX_ITER, 32, iteration limit before a forced tie result (1..255).
REQ-004 Port CLK  input  1  single clock, rising edge; all state SHALL be in this one domain.
REQ-005 Port CLR  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  request to run one winner-take-all search.
REQ-007 Port in_vec  input  4*W  four candidates; candidate i occupies bits [i*W +: W].
REQ-008 Port busy  output  1  high from the edge that accepts start until the edge that leaves DONE.
REQ-009 Port done  output  1  high for exactly one cycle when a result is valid.
REQ-010 Port winner  output  2  index of the surviving candidate; valid while done=1.
REQ-011 Port tie  output  1  high with done when there is no unique winner; winner SHALL then be 0.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, CHECK, ITER, DONE.
REQ-013 IDLE: on start=1, the block SHALL latch in_vec into x0..x3, clear the iteration counter, and go to CHECK. start SHALL be ignored in every other state.
REQ-014 CHECK: with nz = count of nonzero x_i:
- nz==1: go to DONE, winner = index of the nonzero x_i, tie=0.
- nz==0: go to DONE, tie=1.
- iteration counter == MAX_ITER: go to DONE, tie=1.
- otherwise: go to ITER.
REQ-015 ITER: with S = x0+x1+x2+x3 at W+2 bits, each x_i SHALL update simultaneously to max(0, x_i - ((S - x_i) >> EPS_SHIFT)). The block SHALL use signed W+3-bit intermediates, clamp to 0 on a negative result, and never wrap. The iteration counter SHALL increment, and the FSM SHALL return to CHECK.
REQ-016 DONE: done=1 for one cycle, then the FSM SHALL go to IDLE. winner and tie SHALL hold their value until the next start is accepted.
REQ-017 Latency for N iterations: done SHALL be high in the cycle after edge 2N+2, counting the edge that accepts start as edge 1.
REQ-018 start asserted in the DONE cycle SHALL be ignored. start is accepted only in IDLE, at the earliest one cycle later.

Reset
REQ-019 CLR=1 SHALL force the following immediately and asynchronously, including mid-ITER or mid-CHECK:
- state=IDLE
- x0..x3=0, iteration counter=0
- busy=0, done=0, winner=0, tie=0
REQ-020 After CLR deasserts, the first rising edge SHALL behave as IDLE.

Configuration
REQ-021 Macro MAXNET_ITER_COUNT_EN defined: the block SHALL add output port iter_cnt (8 bits), equal to the number of ITER cycles executed and held with winner.
REQ-022 Macro MAXNET_ITER_COUNT_EN undefined: iter_cnt SHALL be absent. All other behaviour SHALL be identical, and the internal counter SHALL remain for the MAX_ITER check.

Structure
REQ-023 Package maxnet_pkg SHALL hold:
- the state enum type
- candidate count constant NCAND=4
- the default constants for W and EPS_SHIFT
REQ-024 One sub-module maxnet_pe SHALL implement a single candidate's clamped update (inputs x_i and S, output next x_i). It SHALL be instantiated four times.

Verification
REQ-025 in_vec={x3=200,x2=30,x1=20,x0=10}, EPS_SHIFT=3 -> after iteration 1 x={193,2,0,0}, after iteration 2 x={193,0,0,0}; winner=3, tie=0, done in cycle after edge 6, iter_cnt=2.
REQ-026 in_vec={0,55,0,0} (x2=55) -> no ITER; winner=2, tie=0, done in cycle after edge 2, iter_cnt=0.
REQ-027 in_vec all 0 -> done after edge 2 with tie=1, winner=0.
REQ-028 x0=x1=50, others 0 -> values converge and stall at 7 and 7; after MAX_ITER=32 iterations, done with tie=1, winner=0, iter_cnt=32.
REQ-029 CLR pulsed asynchronously during the 1st ITER of scenario REQ-025 -> all outputs 0 and busy=0 within the pulse, no done. A following start with the same vector reproduces REQ-025 exactly.
REQ-030 start held high continuously across two runs -> second run accepted only on the edge after DONE. start pulsed while busy -> no effect on x, counter, or result.
